mips_fetch_issue: RTL and testbench
===================================

Name: mips_fetch_issue

Overview:
- Front-end sequencer on the producing side of the main control decoder.
- Owns the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Presents each instruction, and its OpCode field, to the control decoder and datapath over a valid/ready handshake.
- Consumes the decoder's Branch output and the ALU Zero flag to choose the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ImemReq  out  1  instruction-memory request; high only in FETCH.
- ImemAddr  out  32  fetch address, equal to PC.
- ImemAck  in  1  memory has ImemData valid this cycle.
- ImemData  in  32  instruction word returned by memory.
- Instr  out  32  registered instruction being issued.
- OpCode  out  6  Instr[31:26]; feeds the control decoder.
- InstrValid  out  1  Instr/OpCode valid; high only in ISSUE.
- InstrReady  in  1  downstream accepts the instruction this cycle.
- Branch  in  1  from the control decoder; sampled only on the issue handshake.
- Zero  in  1  ALU zero flag; sampled only on the issue handshake.
- PC  out  32  current program counter.
- IssueCount  out  CNT_W  number of instructions issued since reset.

Behaviour:
- Reset is synchronous and active-high and wins over every other event.
  - PC=RESET_PC, Instr=0, OpCode=0, IssueCount=0, state=IDLE, so ImemReq=0 and InstrValid=0.
- FSM states: IDLE, FETCH, ISSUE. ImemReq=(state==FETCH); InstrValid=(state==ISSUE); both decode from the state register with no glitch paths from inputs.
- IDLE: go to FETCH unconditionally. First ImemReq appears 1 cycle after reset deasserts.
- FETCH:
  - ImemReq=1; ImemAddr=PC, held stable until ack.
  - On ImemAck: Instr<=ImemData, go to ISSUE.
  - No ack: stay, with no timeout.
  - An ack arriving in the same cycle ImemReq first rises is legal, giving a 1-cycle fetch.
- ISSUE:
  - InstrValid=1; Instr and OpCode held stable while InstrReady=0.
  - On InstrValid&InstrReady (the handshake cycle):
    - Taken branch (Branch&Zero=1): PC<=PC+4+({{14{Instr[15]}},Instr[15:0],2'b00}).
    - Otherwise: PC<=PC+4.
    - IssueCount<=IssueCount+1.
    - Go to FETCH.
  - Branch and Zero are ignored in every other cycle.
- Arithmetic:
  - PC math is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
  - Backward offsets are sign-extended.
  - PC[1:0] remains 0.
  - IssueCount wraps modulo 2^CNT_W.
- ImemAck outside FETCH (IDLE, ISSUE, or the cycle after reset) is ignored; Instr must not change.
- Reset mid-FETCH: ImemReq drops the next cycle. A late ack after reset does not load Instr.
- Reset mid-ISSUE: the instruction is discarded with no count increment and no PC update.
- Throughput: at best 1 instruction per 2 cycles (FETCH+ISSUE); no prefetch.
- OpCode is combinational from the Instr register, so it carries no extra latency.

Test Plan:
- Reset, then 1-cycle-ack memory returning 32'h0000_0020 at 0 and 32'h8C01_0004 at 4, InstrReady=1 → ImemAddr sequence 0, 4, 8. OpCodes 6'h00 then 6'h23. IssueCount=2 after the second handshake.
- beq 32'h1000_0003 at PC=8 with Branch=1, Zero=1 → next ImemAddr=8+4+12=24. With Zero=0 → 12. With Branch=1, Zero=1 but InstrReady=0 for 3 cycles → PC stays 8 and Instr is stable throughout.
- Backward branch: imm 16'hFFFE at PC=16, taken → next PC=12. Set RESET_PC=32'hFFFF_FFFC with a non-branch → next ImemAddr=0.
- Ack delayed 5 cycles, plus spurious ImemAck=1 during ISSUE and IDLE → ImemReq held and ImemAddr stable for 5 cycles; Instr unchanged by the spurious acks.
- Reset asserted in the middle of FETCH, then again with InstrValid=1 → the next cycle shows PC=RESET_PC, ImemReq=0, InstrValid=0, IssueCount=0. A late ack does not load Instr.
- IssueCount with CNT_W=4, 17 issues → reads 1.

Source files
------------

// File: rtl/mips_fetch_issue.sv
// mips_fetch_issue
// Front-end sequencer feeding the main control decoder. Owns the program
// counter, fetches one 32-bit word per instruction from instruction memory
// over a req/ack handshake, then issues it (with its OpCode field) to the
// decoder/datapath over a valid/ready handshake. The decoder's Branch output
// and the ALU Zero flag, sampled on the issue handshake, select the next PC.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ImemReq/ImemAddr        fetch request and address (address == PC)
//   ImemAck/ImemData        memory response, data valid while ack is high
//   Instr/OpCode/InstrValid registered instruction, its opcode, valid flag
//   InstrReady              downstream accepts the instruction
//   Branch/Zero             next-PC selection, used only on the handshake
//   PC                      current program counter
//   IssueCount              instructions issued since reset (wrapping)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset; moves to FETCH on the next cycle
// FETCH | ImemReq high at address PC, waiting (unbounded) for ImemAck
// ISSUE | InstrValid high, Instr held until InstrReady; PC updated then
module mips_fetch_issue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ImemReq,
  output logic [31:0]      ImemAddr,
  input  logic             ImemAck,
  input  logic [31:0]      ImemData,
  output logic [31:0]      Instr,
  output logic [5:0]       OpCode,
  output logic             InstrValid,
  input  logic             InstrReady,
  input  logic             Branch,
  input  logic             Zero,
  output logic [31:0]      PC,
  output logic [CNT_W-1:0] IssueCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t state, nextState;

  logic [31:0]      pcQ;
  logic [31:0]      instrQ;
  logic [CNT_W-1:0] issueCnt;

  logic        fetchDone;
  logic        issueFire;
  logic        branchTaken;
  logic [31:0] pcPlus4;
  logic [31:0] branchOffset;
  logic [31:0] pcNext;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = FETCH;
      FETCH:   if (ImemAck)    nextState = ISSUE;
      ISSUE:   if (InstrReady) nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  // Handshake qualifiers: acks and branch inputs only matter in their state.
  assign fetchDone = (state == FETCH) && ImemAck;
  assign issueFire = (state == ISSUE) && InstrReady;

  // Word offset of the held instruction, sign-extended so backward branches
  // subtract; all PC arithmetic wraps silently modulo 2^32.
  assign branchOffset = {{14{instrQ[15]}}, instrQ[15:0], 2'b00};
  assign pcPlus4      = pcQ + 32'd4;
  assign branchTaken  = Branch && Zero;
  assign pcNext       = branchTaken ? (pcPlus4 + branchOffset) : pcPlus4;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pcQ      <= RESET_PC;
      instrQ   <= 32'h0000_0000;
      issueCnt <= '0;
    end else begin
      if (fetchDone) begin
        instrQ <= ImemData;
      end
      if (issueFire) begin
        pcQ      <= pcNext;
        issueCnt <= issueCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Handshake outputs decode purely from the state register.
  assign ImemReq    = (state == FETCH);
  assign InstrValid = (state == ISSUE);
  assign ImemAddr   = pcQ;
  assign PC         = pcQ;
  assign Instr      = instrQ;
  assign OpCode     = instrQ[31:26];
  assign IssueCount = issueCnt;

endmodule

// File: tb/tb_mips_fetch_issue.sv
// Directed bench for mips_fetch_issue. dut0 uses default parameters;
// dut1 uses RESET_PC=32'hFFFF_FFFC and CNT_W=4 for the wrap scenarios.
module tb_mips_fetch_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic        reset, ImemAck, InstrReady, Branch, Zero;
  logic [31:0] ImemData;
  logic        ImemReq, InstrValid;
  logic [31:0] ImemAddr, Instr, PC;
  logic [5:0]  OpCode;
  logic [15:0] IssueCount;

  // dut1 signals
  logic        d1Reset, d1Ack, d1Ready, d1Branch, d1Zero;
  logic [31:0] d1Data;
  logic        d1Req, d1Valid;
  logic [31:0] d1Addr, d1Instr, d1Pc;
  logic [5:0]  d1OpCode;
  logic [3:0]  d1Count;

  int nChecks = 0;
  int nFails  = 0;

  mips_fetch_issue dut0 (
    .clk(clk), .reset(reset),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
    .Instr(Instr), .OpCode(OpCode), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Branch(Branch), .Zero(Zero), .PC(PC), .IssueCount(IssueCount)
  );

  mips_fetch_issue #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut1 (
    .clk(clk), .reset(d1Reset),
    .ImemReq(d1Req), .ImemAddr(d1Addr), .ImemAck(d1Ack), .ImemData(d1Data),
    .Instr(d1Instr), .OpCode(d1OpCode), .InstrValid(d1Valid), .InstrReady(d1Ready),
    .Branch(d1Branch), .Zero(d1Zero), .PC(d1Pc), .IssueCount(d1Count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus helpers: one-cycle ack of a word, and one handshake cycle.
  task automatic doFetch(input logic [31:0] data);
    ImemAck = 1'b1; ImemData = data;
    tick();
    ImemAck = 1'b0;
  endtask

  task automatic doIssue(input logic b, input logic z);
    InstrReady = 1'b1; Branch = b; Zero = z;
    tick();
    InstrReady = 1'b0; Branch = 1'b0; Zero = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ImemAck = 1'b1; ImemData = 32'hDEAD_BEEF;
    tick();
    nChecks++; if (PC !== 32'h0) begin nFails++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
    nChecks++; if (ImemReq !== 1'b0 || InstrValid !== 1'b0) begin nFails++; $display("FAIL reset_hs got req=%b valid=%b exp 0/0", ImemReq, InstrValid); end
    nChecks++; if (Instr !== 32'h0 || OpCode !== 6'h0) begin nFails++; $display("FAIL reset_instr got=%h op=%h exp 0", Instr, OpCode); end
    nChecks++; if (IssueCount !== 16'd0) begin nFails++; $display("FAIL reset_count got=%0d exp=0", IssueCount); end
    // ack in the cycle after reset (IDLE) must be ignored
    reset = 1'b0;
    tick();
    ImemAck = 1'b0;
    nChecks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin nFails++; $display("FAIL first_req got req=%b addr=%h exp 1/0", ImemReq, ImemAddr); end
    nChecks++; if (Instr !== 32'h0) begin nFails++; $display("FAIL idle_ack got=%h exp=0", Instr); end
  endtask

  task automatic test_sequential();
    doFetch(32'h0000_0020);
    nChecks++; if (InstrValid !== 1'b1 || ImemReq !== 1'b0) begin nFails++; $display("FAIL seq_valid0 got valid=%b req=%b exp 1/0", InstrValid, ImemReq); end
    nChecks++; if (Instr !== 32'h0000_0020 || OpCode !== 6'h00) begin nFails++; $display("FAIL seq_instr0 got=%h op=%h exp 00000020/00", Instr, OpCode); end
    doIssue(1'b0, 1'b0);
    nChecks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin nFails++; $display("FAIL seq_addr4 got req=%b addr=%h exp 1/4", ImemReq, ImemAddr); end
    doFetch(32'h8C01_0004);
    nChecks++; if (OpCode !== 6'h23) begin nFails++; $display("FAIL seq_op1 got=%h exp=23", OpCode); end
    doIssue(1'b0, 1'b0);
    nChecks++; if (ImemAddr !== 32'h8) begin nFails++; $display("FAIL seq_addr8 got=%h exp=8", ImemAddr); end
    nChecks++; if (IssueCount !== 16'd2) begin nFails++; $display("FAIL seq_count got=%0d exp=2", IssueCount); end
  endtask

  task automatic test_branch_stall();
    doFetch(32'h1000_0003);
    nChecks++; if (OpCode !== 6'h04) begin nFails++; $display("FAIL beq_op got=%h exp=04", OpCode); end
    Branch = 1'b1; Zero = 1'b1; InstrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++;
      if (PC !== 32'h8 || Instr !== 32'h1000_0003 || InstrValid !== 1'b1) begin
        nFails++; $display("FAIL stall_%0d got pc=%h instr=%h valid=%b exp 8/10000003/1", i, PC, Instr, InstrValid);
      end
    end
    doIssue(1'b1, 1'b1);
    nChecks++; if (ImemAddr !== 32'd24) begin nFails++; $display("FAIL beq_taken got=%h exp=%h", ImemAddr, 32'd24); end
    nChecks++; if (IssueCount !== 16'd3) begin nFails++; $display("FAIL beq_count got=%0d exp=3", IssueCount); end
  endtask

  task automatic test_not_taken_and_backward();
    doReset();
    doFetch(32'h0); doIssue(1'b0, 1'b0);
    doFetch(32'h0); doIssue(1'b0, 1'b0);
    nChecks++; if (ImemAddr !== 32'h8) begin nFails++; $display("FAIL nt_setup got=%h exp=8", ImemAddr); end
    doFetch(32'h1000_0003); doIssue(1'b1, 1'b0);
    nChecks++; if (ImemAddr !== 32'd12) begin nFails++; $display("FAIL nt_zero0 got=%h exp=%h", ImemAddr, 32'd12); end
    doFetch(32'h1000_0003); doIssue(1'b0, 1'b1);
    nChecks++; if (ImemAddr !== 32'd16) begin nFails++; $display("FAIL nt_branch0 got=%h exp=%h", ImemAddr, 32'd16); end
    doFetch(32'h1000_FFFE); doIssue(1'b1, 1'b1);
    nChecks++; if (ImemAddr !== 32'd12) begin nFails++; $display("FAIL back_taken got=%h exp=%h", ImemAddr, 32'd12); end
    nChecks++; if (IssueCount !== 16'd5) begin nFails++; $display("FAIL nt_count got=%0d exp=5", IssueCount); end
  endtask

  task automatic test_delayed_ack();
    for (int i = 0; i < 5; i++) begin
      tick();
      nChecks++;
      if (ImemReq !== 1'b1 || ImemAddr !== 32'd12 || Instr !== 32'h1000_FFFE) begin
        nFails++; $display("FAIL wait_%0d got req=%b addr=%h instr=%h exp 1/c/1000fffe", i, ImemReq, ImemAddr, Instr);
      end
    end
    doFetch(32'h0123_4567);
    nChecks++; if (Instr !== 32'h0123_4567) begin nFails++; $display("FAIL late_load got=%h exp=01234567", Instr); end
    ImemAck = 1'b1; ImemData = 32'hFFFF_0000;
    tick(); tick();
    ImemAck = 1'b0;
    nChecks++; if (Instr !== 32'h0123_4567 || InstrValid !== 1'b1) begin nFails++; $display("FAIL issue_ack got=%h valid=%b exp 01234567/1", Instr, InstrValid); end
    doIssue(1'b0, 1'b0);
    nChecks++; if (ImemAddr !== 32'd16 || IssueCount !== 16'd6) begin nFails++; $display("FAIL delay_done got addr=%h cnt=%0d exp 10/6", ImemAddr, IssueCount); end
  endtask

  task automatic test_reset_mid();
    // in FETCH at PC 16
    reset = 1'b1;
    tick();
    nChecks++;
    if (PC !== 32'h0 || ImemReq !== 1'b0 || InstrValid !== 1'b0 || IssueCount !== 16'd0) begin
      nFails++; $display("FAIL rst_fetch got pc=%h req=%b valid=%b cnt=%0d exp 0/0/0/0", PC, ImemReq, InstrValid, IssueCount);
    end
    reset = 1'b0; ImemAck = 1'b1; ImemData = 32'hCAFE_F00D;
    tick();
    ImemAck = 1'b0;
    nChecks++; if (Instr !== 32'h0) begin nFails++; $display("FAIL rst_late_ack got=%h exp=0", Instr); end
    doFetch(32'h1000_0003);
    nChecks++; if (InstrValid !== 1'b1) begin nFails++; $display("FAIL rst_pre_issue got valid=%b exp 1", InstrValid); end
    reset = 1'b1; InstrReady = 1'b1; Branch = 1'b1; Zero = 1'b1;
    tick();
    reset = 1'b0; InstrReady = 1'b0; Branch = 1'b0; Zero = 1'b0;
    nChecks++;
    if (PC !== 32'h0 || ImemReq !== 1'b0 || InstrValid !== 1'b0 || IssueCount !== 16'd0) begin
      nFails++; $display("FAIL rst_issue got pc=%h req=%b valid=%b cnt=%0d exp 0/0/0/0", PC, ImemReq, InstrValid, IssueCount);
    end
  endtask

  task automatic test_wrap();
    d1Reset = 1'b0;
    tick();
    nChecks++; if (d1Req !== 1'b1 || d1Addr !== 32'hFFFF_FFFC) begin nFails++; $display("FAIL wrap_start got req=%b addr=%h exp 1/fffffffc", d1Req, d1Addr); end
    d1Ack = 1'b1; d1Data = 32'h2000_0001;
    tick();
    d1Ack = 1'b0;
    nChecks++; if (d1Valid !== 1'b1 || d1OpCode !== 6'h08) begin nFails++; $display("FAIL wrap_issue got valid=%b op=%h exp 1/08", d1Valid, d1OpCode); end
    d1Ready = 1'b1;
    tick();
    d1Ready = 1'b0;
    nChecks++; if (d1Addr !== 32'h0 || d1Count !== 4'd1) begin nFails++; $display("FAIL wrap_pc got addr=%h cnt=%0d exp 0/1", d1Addr, d1Count); end
    for (int i = 0; i < 16; i++) begin
      d1Ack = 1'b1; tick(); d1Ack = 1'b0;
      d1Ready = 1'b1; tick(); d1Ready = 1'b0;
      if (i == 14) begin
        nChecks++; if (d1Count !== 4'd0) begin nFails++; $display("FAIL cnt16 got=%0d exp=0", d1Count); end
      end
    end
    nChecks++; if (d1Count !== 4'd1 || d1Addr !== 32'd64 || d1Instr !== 32'h2000_0001) begin nFails++; $display("FAIL cnt17 got cnt=%0d addr=%h instr=%h exp 1/40/20000001", d1Count, d1Addr, d1Instr); end
  endtask

  initial begin
    reset = 1'b1; ImemAck = 1'b0; ImemData = 32'h0; InstrReady = 1'b0; Branch = 1'b0; Zero = 1'b0;
    d1Reset = 1'b1; d1Ack = 1'b0; d1Data = 32'h0; d1Ready = 1'b0; d1Branch = 1'b0; d1Zero = 1'b0;
    tick();
    test_reset();
    test_sequential();
    test_branch_stall();
    test_not_taken_and_backward();
    test_delayed_ack();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
